// File: rtl/uart_arb_pkg.sv
// uart_arb_pkg
// Shared definitions for the UART transmit arbiter and related UART blocks:
//   BYTE_W       width of one UART data byte
//   arb_state_t  arbiter FSM encoding (IDLE, LAUNCH, WAIT_DONE, GAP)
//   clog2()      index width helper (never returns less than 1)
// No ports (package).
package uart_arb_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_DONE = 2'd2,
    GAP       = 2'd3
  } arb_state_t;

  // Bits needed to index n items; a single-item index still gets one bit so
  // that port vectors never collapse to zero width.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    if (r < 1) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if
// Bundles the requester side and the UART transmitter side of the arbiter.
//   req, req_data      requester levels and their bytes (byte i on [8i+7:8i])
//   gnt, owner, busy   grant pulse, last granted index, arbiter activity
//   tx_start, tx_data  launch pulse and byte to the UART transmitter
//   tx_done            frame-complete pulse from the transmitter
//   timeout_err        watchdog expiry pulse
// Modports: master = arbiter, slave = surrounding system / bench.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4
);
  import uart_arb_pkg::*;

  localparam int IDX_W = clog2(NUM_REQ);

  logic [NUM_REQ-1:0]        req;
  logic [BYTE_W*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]        gnt;
  logic [IDX_W-1:0]          owner;
  logic                      busy;
  logic                      tx_start;
  logic [BYTE_W-1:0]         tx_data;
  logic                      tx_done;
  logic                      timeout_err;

  modport master (
    input  req, req_data, tx_done,
    output gnt, owner, busy, tx_start, tx_data, timeout_err
  );

  modport slave (
    output req, req_data, tx_done,
    input  gnt, owner, busy, tx_start, tx_data, timeout_err
  );

endinterface

// File: rtl/rr_pick.sv
// rr_pick
// Combinational round-robin picker. Starting just after ptr and wrapping
// modulo NUM_REQ, returns the first asserted request.
//   req    in   NUM_REQ  request levels
//   ptr    in   IDX_W    index of the most recently served requester
//   valid  out  1        at least one request asserted
//   idx    out  IDX_W    winning index (0 when valid is low)
module rr_pick
  import uart_arb_pkg::*;
#(
  parameter int  NUM_REQ = 4,
  localparam int IDX_W   = clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic               valid,
  output logic [IDX_W-1:0]   idx
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    valid = |req;
    idx   = '0;
    cand  = '0;
    // Walk from the farthest position back to ptr+1 so the nearest asserted
    // request after ptr overwrites any farther one.
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = IDX_W'((int'(ptr) + k) % NUM_REQ);
      if (req[cand]) idx = cand;
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
// Shares one UART transmitter among NUM_REQ byte producers. Round-robin
// grant in IDLE captures the winner's byte, LAUNCH issues a start pulse,
// WAIT_DONE waits for the frame-complete pulse, GAP holds off the next grant
// for GAP_CYCLES cycles.
// Ports:
//   clk  in  system clock, rising edge
//   rst  in  asynchronous active-high reset
//   bus  uart_tx_arbiter_if.master (req/req_data/tx_done in;
//        gnt/owner/busy/tx_start/tx_data/timeout_err out)
// Build option: define UART_ARB_TIMEOUT_EN to add a WAIT_DONE watchdog that
// pulses timeout_err and drops the frame after TIMEOUT_CYCLES cycles.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int GAP_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES = 12000
) (
  input  logic                     clk,
  input  logic                     rst,
  uart_tx_arbiter_if.master        bus
);

  localparam int IDX_W   = clog2(NUM_REQ);
  // One counter times the inter-frame gap and, when enabled, the watchdog;
  // it is sized for the longer of the two limits.
  localparam int CNT_MAX = (GAP_CYCLES > TIMEOUT_CYCLES) ? GAP_CYCLES : TIMEOUT_CYCLES;
  localparam int CNT_W   = clog2(CNT_MAX + 1);

  arb_state_t         state_reg, state_next;
  logic [IDX_W-1:0]   ptr_reg, ptr_next;
  logic [IDX_W-1:0]   owner_reg, owner_next;
  logic [NUM_REQ-1:0] gnt_reg, gnt_next;
  logic               tx_start_reg, tx_start_next;
  logic [BYTE_W-1:0]  tx_data_reg, tx_data_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
`ifdef UART_ARB_TIMEOUT_EN
  logic               timeout_err_reg, timeout_err_next;
`endif

  logic               pick_valid;
  logic [IDX_W-1:0]   pick_idx;
  logic [BYTE_W-1:0]  req_bytes [NUM_REQ];

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_bytes
      assign req_bytes[gi] = bus.req_data[gi*BYTE_W +: BYTE_W];
    end
  endgenerate

  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req   (bus.req),
    .ptr   (ptr_reg),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= IDLE;
      ptr_reg         <= IDX_W'(NUM_REQ - 1);  // requester 0 searched first
      owner_reg       <= '0;
      gnt_reg         <= '0;
      tx_start_reg    <= 1'b0;
      tx_data_reg     <= '0;
      cnt_reg         <= '0;
`ifdef UART_ARB_TIMEOUT_EN
      timeout_err_reg <= 1'b0;
`endif
    end else begin
      state_reg       <= state_next;
      ptr_reg         <= ptr_next;
      owner_reg       <= owner_next;
      gnt_reg         <= gnt_next;
      tx_start_reg    <= tx_start_next;
      tx_data_reg     <= tx_data_next;
      cnt_reg         <= cnt_next;
`ifdef UART_ARB_TIMEOUT_EN
      timeout_err_reg <= timeout_err_next;
`endif
    end
  end

  // gnt and tx_start are registered, so the grant shows in the cycle the FSM
  // sits in LAUNCH and the start pulse in the first WAIT_DONE cycle; the two
  // can therefore never coincide.
  always_comb begin
    state_next       = state_reg;
    ptr_next         = ptr_reg;
    owner_next       = owner_reg;
    gnt_next         = '0;
    tx_start_next    = 1'b0;
    tx_data_next     = tx_data_reg;
    cnt_next         = cnt_reg;
`ifdef UART_ARB_TIMEOUT_EN
    timeout_err_next = 1'b0;
`endif
    case (state_reg)
      IDLE: begin
        if (pick_valid) begin
          gnt_next     = NUM_REQ'(1) << pick_idx;
          owner_next   = pick_idx;
          tx_data_next = req_bytes[pick_idx];
          ptr_next     = pick_idx;
          state_next   = LAUNCH;
        end
      end
      LAUNCH: begin
        tx_start_next = 1'b1;
        cnt_next      = '0;
        state_next    = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (bus.tx_done) begin
          cnt_next   = '0;
          state_next = GAP;
        end
`ifdef UART_ARB_TIMEOUT_EN
        else if (cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          // Frame abandoned, no retry.
          timeout_err_next = 1'b1;
          cnt_next         = '0;
          state_next       = GAP;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
`endif
      end
      GAP: begin
        if (cnt_reg == CNT_W'(GAP_CYCLES - 1)) begin
          state_next = IDLE;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.gnt         = gnt_reg;
  assign bus.owner       = owner_reg;
  assign bus.busy        = (state_reg != IDLE);
  assign bus.tx_start    = tx_start_reg;
  assign bus.tx_data     = tx_data_reg;
`ifdef UART_ARB_TIMEOUT_EN
  assign bus.timeout_err = timeout_err_reg;
`else
  assign bus.timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter
// Self-checking bench for uart_tx_arbiter (NUM_REQ=4, GAP_CYCLES=16,
// TIMEOUT_CYCLES=50). Expected bytes/owners are queued when requests are
// raised and compared when tx_start appears; a small transmitter model
// returns tx_done a programmable number of cycles after each start.
module tb_uart_tx_arbiter;
  import uart_arb_pkg::*;

  localparam int N   = 4;
  localparam int GAP = 16;
  localparam int TMO = 50;
`ifdef UART_ARB_TIMEOUT_EN
  localparam int EXP_TO = 1;
`else
  localparam int EXP_TO = 0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.NUM_REQ(N)) bus ();

  uart_tx_arbiter #(
    .NUM_REQ        (N),
    .GAP_CYCLES     (GAP),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  typedef struct packed {
    logic [7:0] data;
    logic [1:0] owner;
  } exp_t;
  exp_t exp_q[$];

  // requester model: each requester sends its listed bytes in order
  logic [7:0] rq_bytes [N][4];
  int         rq_cnt [N];
  int         rq_pos [N];

  int cyc = 0;
  int done_cnt = 0;
  int done_delay = 0;
  bit force_done = 1'b0;
  int gnt_cyc = -1, start_cyc = -1, done_cyc = -1, err_cyc = -1;
  int gnt_total = 0, start_total = 0, err_total = 0;
  logic [N-1:0] last_gnt = '0;

  task automatic clear_reqs();
    bus.req = '0;
    for (int i = 0; i < N; i++) begin
      rq_cnt[i] = 0;
      rq_pos[i] = 0;
    end
  endtask

  task automatic add_req(input int i, input logic [7:0] b);
    rq_bytes[i][rq_cnt[i]] = b;
    rq_cnt[i]++;
    if (!bus.req[i]) begin
      bus.req_data[8*i +: 8] = b;
      bus.req[i] = 1'b1;
    end
  endtask

  task automatic push_exp(input logic [7:0] d, input logic [1:0] o);
    exp_t e;
    e.data  = d;
    e.owner = o;
    exp_q.push_back(e);
  endtask

  // One clock: observe outputs 1 time unit after the edge, then drive.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    cyc++;
    #1;
    bus.tx_done = 1'b0;
    if (bus.gnt != '0) begin
      gnt_total++;
      gnt_cyc  = cyc;
      last_gnt = bus.gnt;
      check_eq("gnt_onehot", 32'($onehot(bus.gnt)), 1);
      check_eq("gnt_with_start", 32'(bus.tx_start), 0);
      if (done_cyc >= 0) check_eq("gap_min", 32'((cyc - done_cyc) >= GAP + 1), 1);
      for (int i = 0; i < N; i++) begin
        if (bus.gnt[i]) begin
          rq_pos[i]++;
          if (rq_pos[i] < rq_cnt[i]) bus.req_data[8*i +: 8] = rq_bytes[i][rq_pos[i]];
          else bus.req[i] = 1'b0;
        end
      end
    end
    if (bus.tx_start) begin
      start_total++;
      start_cyc = cyc;
      check_eq("sb_nonempty", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check_eq("tx_data", 32'(bus.tx_data), 32'(e.data));
        check_eq("owner", 32'(bus.owner), 32'(e.owner));
      end
      $display("tx cyc=%0d owner=%0d data=%02h", cyc, bus.owner, bus.tx_data);
      if (done_delay > 0) done_cnt = done_delay;
    end
    if (bus.timeout_err) begin
      err_total++;
      err_cyc = cyc;
    end
    if (done_cnt > 0) begin
      done_cnt--;
      if (done_cnt == 0) begin
        bus.tx_done = 1'b1;
        done_cyc = cyc;
      end
    end
    if (force_done) begin
      bus.tx_done = 1'b1;
      force_done = 1'b0;
    end
  endtask

  task automatic wait_starts(input string tag, input int target, input int max);
    for (int k = 0; k < max && start_total < target; k++) tick();
    check_eq(tag, start_total, target);
  endtask

  task automatic wait_idle(input string tag, input int max);
    for (int k = 0; k < max && bus.busy; k++) tick();
    check_eq(tag, 32'(bus.busy), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int req_cyc;
    int s0;
    int g0;
    rst = 1'b0;
    bus.req = '0;
    bus.req_data = '0;
    bus.tx_done = 1'b0;
    clear_reqs();
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset_outputs",
             32'({bus.gnt, bus.owner, bus.busy, bus.tx_start, bus.tx_data, bus.timeout_err}), 0);
    rst = 1'b0;

    // single request from requester 2
    add_req(2, 8'hA5);
    push_exp(8'hA5, 2'd2);
    req_cyc = cyc;
    done_delay = 100;
    wait_starts("single_start", 1, 20);
    check_eq("single_gnt", 32'(last_gnt), 32'h4);
    check_eq("single_gnt_lat", gnt_cyc - req_cyc, 1);
    check_eq("single_start_lat", start_cyc - gnt_cyc, 1);
    wait_idle("single_idle", 300);
    check_eq("single_gap_len", cyc - done_cyc, GAP + 1);

    // reset in the middle of a frame
    add_req(0, 8'h55);
    push_exp(8'h55, 2'd0);
    done_delay = 0;
    wait_starts("midrst_start", 2, 20);
    repeat (3) tick();
    #2 rst = 1'b1;
    #1;
    check_eq("midrst_async",
             32'({bus.gnt, bus.owner, bus.busy, bus.tx_start, bus.tx_data, bus.timeout_err}), 0);
    clear_reqs();
    done_cnt = 0;
    done_cyc = -1;
    @(negedge clk);
    rst = 1'b0;

    // fairness: all four request, requester 0 holds on for a second byte
    g0 = gnt_total;
    s0 = start_total;
    add_req(0, 8'h10);
    add_req(0, 8'h10);
    add_req(1, 8'h20);
    add_req(2, 8'h30);
    add_req(3, 8'h40);
    push_exp(8'h10, 2'd0);
    push_exp(8'h20, 2'd1);
    push_exp(8'h30, 2'd2);
    push_exp(8'h40, 2'd3);
    push_exp(8'h10, 2'd0);
    done_delay = 5;
    for (int k = 0; k < 10 && gnt_total == g0; k++) tick();
    check_eq("rst_first_gnt", 32'(last_gnt), 32'h1);
    wait_starts("fair_starts", s0 + 5, 400);
    wait_idle("fair_idle", 100);
    check_eq("fair_reqs_dropped", 32'(bus.req), 0);

    // spurious tx_done while idle
    s0 = start_total;
    force_done = 1'b1;
    repeat (4) tick();
    check_eq("spur_idle_busy", 32'(bus.busy), 0);
    check_eq("spur_idle_start", start_total, s0);

    // spurious tx_done during the gap
    add_req(1, 8'h77);
    push_exp(8'h77, 2'd1);
    done_delay = 3;
    wait_starts("spur_gap_start", s0 + 1, 20);
    for (int k = 0; k < 20 && done_cnt > 0; k++) tick();
    repeat (4) tick();
    force_done = 1'b1;
    tick();
    wait_idle("spur_gap_idle", 100);
    check_eq("spur_gap_len", cyc - done_cyc, GAP + 1);
    repeat (5) tick();
    check_eq("spur_gap_nostart", start_total, s0 + 1);

    // transmitter never answers
    s0 = start_total;
    add_req(3, 8'h99);
    push_exp(8'h99, 2'd3);
    done_delay = 0;
    wait_starts("to_first_start", s0 + 1, 20);
    add_req(0, 8'h11);
    push_exp(8'h11, 2'd0);
`ifdef UART_ARB_TIMEOUT_EN
    for (int k = 0; k < 200 && err_total == 0; k++) tick();
    check_eq("to_pulse", err_total, 1);
    check_eq("to_latency", err_cyc - start_cyc, TMO);
    tick();
    check_eq("to_pulse_width", 32'(bus.timeout_err), 0);
    done_delay = 5;
    wait_starts("to_next_start", s0 + 2, 100);
    check_eq("to_next_gnt", 32'(last_gnt), 32'h1);
    check_eq("to_next_gap", 32'((gnt_cyc - err_cyc) >= GAP + 1), 1);
    wait_idle("to_idle", 100);
`else
    repeat (200) tick();
    check_eq("noto_busy", 32'(bus.busy), 1);
    check_eq("noto_starts", start_total, s0 + 1);
    #2 rst = 1'b1;
    #1;
    clear_reqs();
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
`endif
    check_eq("to_count", err_total, EXP_TO);
    check_eq("sb_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
